rc4_key_search_ctrl: RTL and testbench

- Top-level sequencer for one RC4 cracking core.
- For each candidate key it runs three phases in order: init (S[i]=i), shuffle (key schedule) and decrypt/check.
- It grants the single S-memory port to whichever phase is active, and steps the key on failure until a valid message is found or the key range is exhausted.
- Sits between the three phase engines and the S RAM.

---
 rtl/rc4_pkg.sv | 63 ++++++
 rtl/rc4_key_search_ctrl_mem_mux.sv | 44 ++++
 rtl/rc4_key_search_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 key-search controller.
// Optional macro RC4_CTRL_STOP_EN adds the DRAIN state used by the external stop request.
package rc4_pkg;

    localparam int KEY_W  = 24;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

`ifdef RC4_CTRL_STOP_EN
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_GO   = 4'd1,
        ST_INIT_WAIT = 4'd2,
        ST_SHUF_GO   = 4'd3,
        ST_SHUF_WAIT = 4'd4,
        ST_DEC_GO    = 4'd5,
        ST_DEC_WAIT  = 4'd6,
        ST_NEXT_KEY  = 4'd7,
        ST_FOUND     = 4'd8,
        ST_FAIL      = 4'd9,
        ST_DRAIN     = 4'd10
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_GO   = 4'd1,
        ST_INIT_WAIT = 4'd2,
        ST_SHUF_GO   = 4'd3,
        ST_SHUF_WAIT = 4'd4,
        ST_DEC_GO    = 4'd5,
        ST_DEC_WAIT  = 4'd6,
        ST_NEXT_KEY  = 4'd7,
        ST_FOUND     = 4'd8,
        ST_FAIL      = 4'd9
    } state_t;
`endif

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_SHUF = 2'd2,
        PH_DEC  = 2'd3
    } phase_t;

    // Grant owned in a given state: GO states claim a new phase, waiting states keep it.
    function automatic phase_t phase_for(input state_t s, input phase_t cur);
        phase_t p;
        case (s)
            ST_INIT_GO:   p = PH_INIT;
            ST_SHUF_GO:   p = PH_SHUF;
            ST_DEC_GO:    p = PH_DEC;
            ST_INIT_WAIT,
            ST_SHUF_WAIT,
`ifdef RC4_CTRL_STOP_EN
            ST_DRAIN,
`endif
            ST_DEC_WAIT:  p = cur;
            default:      p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_mem_mux.sv
// Combinational S-RAM port mux: forwards the granted engine's port, drives zeros when no phase owns it.
module rc4_mem_mux
    import rc4_pkg::*;
(
    input  phase_t              phase_i,
    input  logic [ADDR_W-1:0]   init_addr_i,
    input  logic [DATA_W-1:0]   init_wdata_i,
    input  logic                init_we_i,
    input  logic [ADDR_W-1:0]   shuf_addr_i,
    input  logic [DATA_W-1:0]   shuf_wdata_i,
    input  logic                shuf_we_i,
    input  logic [ADDR_W-1:0]   dec_addr_i,
    input  logic [DATA_W-1:0]   dec_wdata_i,
    input  logic                dec_we_i,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic                s_we_o
);

    always_comb begin
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_we_o    = 1'b0;
        case (phase_i)
            PH_INIT: begin
                s_addr_o  = init_addr_i;
                s_wdata_o = init_wdata_i;
                s_we_o    = init_we_i;
            end
            PH_SHUF: begin
                s_addr_o  = shuf_addr_i;
                s_wdata_o = shuf_wdata_i;
                s_we_o    = shuf_we_i;
            end
            PH_DEC: begin
                s_addr_o  = dec_addr_i;
                s_wdata_o = dec_wdata_i;
                s_we_o    = dec_we_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Sequencer for one RC4 cracking core: init -> shuffle -> decrypt per candidate key, S-RAM grant, key stepping.
// Optional macro RC4_CTRL_STOP_EN adds a stop input that drains the active engine and ends in FAIL.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_MIN  = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_MAX  = 24'h3FFFFF,
    parameter logic [KEY_W-1:0] KEY_STEP = 24'h000001
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef RC4_CTRL_STOP_EN
    input  logic                stop,
`endif
    output logic [KEY_W-1:0]    secret_key,
    output logic                init_start,
    output logic                shuffle_start,
    output logic                decrypt_start,
    input  logic                init_finish,
    input  logic                shuffle_finish,
    input  logic                decrypt_finish,
    input  logic                decrypt_valid,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_wdata,
    input  logic                init_we,
    input  logic [ADDR_W-1:0]   shuf_addr,
    input  logic [DATA_W-1:0]   shuf_wdata,
    input  logic                shuf_we,
    input  logic [ADDR_W-1:0]   dec_addr,
    input  logic [DATA_W-1:0]   dec_wdata,
    input  logic                dec_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic                s_we,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output state_t              dbg_state_o
);

    // Engine handshake: a *_start pulse lasts exactly one cycle (the GO state); the engine
    // answers later with a one-cycle *_finish, honoured only in the matching WAIT/DRAIN state.
    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [KEY_W:0]     key_next_wide;
    logic               last_key;

    // 25-bit sum so a step past 24'hFFFFFF cannot wrap back into range.
    assign key_next_wide = {1'b0, key_q} + {1'b0, KEY_STEP};
    assign last_key      = key_next_wide > {1'b0, KEY_MAX};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_NONE;
            key_q   <= KEY_MIN;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = KEY_MIN;
                    state_d = ST_INIT_GO;
                end
            end
            ST_INIT_GO:   state_d = ST_INIT_WAIT;
            ST_INIT_WAIT: if (init_finish) state_d = ST_SHUF_GO;
            ST_SHUF_GO:   state_d = ST_SHUF_WAIT;
            ST_SHUF_WAIT: if (shuffle_finish) state_d = ST_DEC_GO;
            ST_DEC_GO:    state_d = ST_DEC_WAIT;
            ST_DEC_WAIT: begin
                if (decrypt_finish) state_d = decrypt_valid ? ST_FOUND : ST_NEXT_KEY;
            end
            ST_NEXT_KEY: begin
                if (last_key) begin
                    state_d = ST_FAIL;
                end else begin
                    key_d   = key_next_wide[KEY_W-1:0];
                    state_d = ST_INIT_GO;
                end
            end
            ST_FOUND, ST_FAIL: if (!start) state_d = ST_IDLE;
`ifdef RC4_CTRL_STOP_EN
            ST_DRAIN: begin
                if ((phase_q == PH_INIT && init_finish) || (phase_q == PH_SHUF && shuffle_finish) ||
                    (phase_q == PH_DEC && decrypt_finish) || (phase_q == PH_NONE))
                    state_d = ST_FAIL;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef RC4_CTRL_STOP_EN
        // A finish landing together with stop means nothing is left to drain.
        if (stop) begin
            case (state_q)
                ST_INIT_GO, ST_SHUF_GO, ST_DEC_GO: state_d = ST_DRAIN;
                ST_INIT_WAIT: state_d = init_finish ? ST_FAIL : ST_DRAIN;
                ST_SHUF_WAIT: state_d = shuffle_finish ? ST_FAIL : ST_DRAIN;
                ST_DEC_WAIT:  state_d = decrypt_finish ? ST_FAIL : ST_DRAIN;
                ST_NEXT_KEY: begin
                    state_d = ST_FAIL;
                    key_d   = key_q;
                end
                default: ;
            endcase
        end
`endif
        phase_d = phase_for(state_d, phase_q);
    end

    always_comb begin
        init_start    = 1'b0;
        shuffle_start = 1'b0;
        decrypt_start = 1'b0;
        busy          = 1'b1;
        found         = 1'b0;
        exhausted     = 1'b0;
        case (state_q)
            ST_INIT_GO: init_start    = 1'b1;
            ST_SHUF_GO: shuffle_start = 1'b1;
            ST_DEC_GO:  decrypt_start = 1'b1;
            ST_IDLE:    busy          = 1'b0;
            ST_FOUND: begin
                busy  = 1'b0;
                found = 1'b1;
            end
            ST_FAIL: begin
                busy      = 1'b0;
                exhausted = 1'b1;
            end
            default: ;
        endcase
    end

    assign secret_key  = key_q;
    assign dbg_state_o = state_q;

    rc4_mem_mux u_mem_mux (
        .phase_i      (phase_q),
        .init_addr_i  (init_addr),
        .init_wdata_i (init_wdata),
        .init_we_i    (init_we),
        .shuf_addr_i  (shuf_addr),
        .shuf_wdata_i (shuf_wdata),
        .shuf_we_i    (shuf_we),
        .dec_addr_i   (dec_addr),
        .dec_wdata_i  (dec_wdata),
        .dec_we_i     (dec_we),
        .s_addr_o     (s_addr),
        .s_wdata_o    (s_wdata),
        .s_we_o       (s_we)
    );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: three instances (default range, top-of-range, step 2) share one stub engine set.
// Stop/drain steps are compiled in when RC4_CTRL_STOP_EN is defined.
module tb_rc4_key_search_ctrl;
    import rc4_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- shared engine-side inputs ----------------
    logic start_a, start_b, start_c;
    logic stub_en;
    logic man_init_fin, man_shuf_fin, man_dec_fin, man_dec_valid;
    logic stub_init_fin = 1'b0, stub_shuf_fin = 1'b0, stub_dec_fin = 1'b0, stub_dec_valid = 1'b0;
    logic init_finish, shuffle_finish, decrypt_finish, decrypt_valid;
    logic [7:0] init_addr, init_wdata, shuf_addr, shuf_wdata, dec_addr, dec_wdata;
    logic init_we, shuf_we, dec_we;
`ifdef RC4_CTRL_STOP_EN
    logic stop_a, stop_b, stop_c;
`endif

    assign init_finish    = stub_en ? stub_init_fin  : man_init_fin;
    assign shuffle_finish = stub_en ? stub_shuf_fin  : man_shuf_fin;
    assign decrypt_finish = stub_en ? stub_dec_fin   : man_dec_fin;
    assign decrypt_valid  = stub_en ? stub_dec_valid : man_dec_valid;

    // ---------------- per-instance outputs ----------------
    logic [23:0] key_a, key_b, key_c;
    logic is_a, ss_a, ds_a, is_b, ss_b, ds_b, is_c, ss_c, ds_c;
    logic [7:0] saddr_a, swdata_a, saddr_b, swdata_b, saddr_c, swdata_c;
    logic swe_a, swe_b, swe_c;
    logic busy_a, found_a, exh_a, busy_b, found_b, exh_b, busy_c, found_c, exh_c;
    state_t st_a, st_b, st_c;

    rc4_key_search_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef RC4_CTRL_STOP_EN
        .stop(stop_a),
`endif
        .secret_key(key_a), .init_start(is_a), .shuffle_start(ss_a), .decrypt_start(ds_a),
        .init_finish(init_finish), .shuffle_finish(shuffle_finish),
        .decrypt_finish(decrypt_finish), .decrypt_valid(decrypt_valid),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_we(init_we),
        .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata), .shuf_we(shuf_we),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_we(dec_we),
        .s_addr(saddr_a), .s_wdata(swdata_a), .s_we(swe_a),
        .busy(busy_a), .found(found_a), .exhausted(exh_a), .dbg_state_o(st_a)
    );

    rc4_key_search_ctrl #(.KEY_MIN(24'h3FFFFE), .KEY_MAX(24'h3FFFFF), .KEY_STEP(24'h000001)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef RC4_CTRL_STOP_EN
        .stop(stop_b),
`endif
        .secret_key(key_b), .init_start(is_b), .shuffle_start(ss_b), .decrypt_start(ds_b),
        .init_finish(init_finish), .shuffle_finish(shuffle_finish),
        .decrypt_finish(decrypt_finish), .decrypt_valid(decrypt_valid),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_we(init_we),
        .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata), .shuf_we(shuf_we),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_we(dec_we),
        .s_addr(saddr_b), .s_wdata(swdata_b), .s_we(swe_b),
        .busy(busy_b), .found(found_b), .exhausted(exh_b), .dbg_state_o(st_b)
    );

    rc4_key_search_ctrl #(.KEY_MIN(24'h000001), .KEY_MAX(24'h000006), .KEY_STEP(24'h000002)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
`ifdef RC4_CTRL_STOP_EN
        .stop(stop_c),
`endif
        .secret_key(key_c), .init_start(is_c), .shuffle_start(ss_c), .decrypt_start(ds_c),
        .init_finish(init_finish), .shuffle_finish(shuffle_finish),
        .decrypt_finish(decrypt_finish), .decrypt_valid(decrypt_valid),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_we(init_we),
        .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata), .shuf_we(shuf_we),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_we(dec_we),
        .s_addr(saddr_c), .s_wdata(swdata_c), .s_we(swe_c),
        .busy(busy_c), .found(found_c), .exhausted(exh_c), .dbg_state_o(st_c)
    );

    // ---------------- stub engines: each finishes 3 cycles after its start ----------------
    int          sel = 0;
    logic [23:0] target = 24'hFFFFFF;
    logic [23:0] key_sel;
    int          cnt_i = 0, cnt_s = 0, cnt_d = 0;
    int          n_init = 0;
    logic [23:0] att_q[$];
    logic        even_seen = 1'b0;

    always_comb begin
        case (sel)
            0:       key_sel = key_a;
            1:       key_sel = key_b;
            default: key_sel = key_c;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_i = 0; cnt_s = 0; cnt_d = 0;
            stub_init_fin = 1'b0; stub_shuf_fin = 1'b0; stub_dec_fin = 1'b0; stub_dec_valid = 1'b0;
        end else begin
            stub_init_fin = 1'b0; stub_shuf_fin = 1'b0; stub_dec_fin = 1'b0; stub_dec_valid = 1'b0;
            if (cnt_i == 1) stub_init_fin = 1'b1;
            if (cnt_s == 1) stub_shuf_fin = 1'b1;
            if (cnt_d == 1) begin
                stub_dec_fin   = 1'b1;
                stub_dec_valid = (key_sel == target);
            end
            if (cnt_i > 0) cnt_i--;
            if (cnt_s > 0) cnt_s--;
            if (cnt_d > 0) cnt_d--;
            if (is_a | is_b | is_c) begin
                cnt_i = 3;
                n_init++;
                att_q.push_back(key_sel);
            end
            if (ss_a | ss_b | ss_c) cnt_s = 3;
            if (ds_a | ds_b | ds_c) cnt_d = 3;
            if (sel == 2 && busy_c && !key_c[0]) even_seen = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic state_t st_of(input int which);
        case (which)
            0:       return st_a;
            1:       return st_b;
            default: return st_c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input int which, input state_t s, input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (st_of(which) == s) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_attempts(input int base, input string tag);
        chk(tag, att_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < att_q.size()) chk(tag, {8'd0, att_q[base + i]}, {8'd0, exp_q[i]});
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int    base;
        int    n0;
        logic  ok;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        stub_en = 1'b0;
        man_init_fin = 1'b0; man_shuf_fin = 1'b0; man_dec_fin = 1'b0; man_dec_valid = 1'b0;
        init_addr = 8'h22; init_wdata = 8'h33; init_we = 1'b1;
        shuf_addr = 8'h10; shuf_wdata = 8'h44; shuf_we = 1'b1;
        dec_addr  = 8'h55; dec_wdata  = 8'h66; dec_we  = 1'b1;
`ifdef RC4_CTRL_STOP_EN
        stop_a = 1'b0; stop_b = 1'b0; stop_c = 1'b0;
`endif
        repeat (2) tick();

        // reset values
        chk("rst_state_a", st_a, ST_IDLE);
        chk("rst_key_a", key_a, 24'h000000);
        chk("rst_key_b", key_b, 24'h3FFFFE);
        chk("rst_key_c", key_c, 24'h000001);
        chk("rst_flags_a", {is_a, ss_a, ds_a, swe_a, busy_a, found_a, exh_a}, 7'd0);
        chk("rst_sport_a", {saddr_a, swdata_a}, 16'd0);
        rst_n = 1'b1;
        tick();

        // grant: IDLE ignores engines driving we
        chk("idle_sport", {saddr_a, swdata_a, swe_a}, 17'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("init_go_state", st_a, ST_INIT_GO);
        chk("init_go_pulse", {is_a, ss_a, ds_a, busy_a}, 4'b1001);
        tick();
        chk("init_wait_sport", {saddr_a, swdata_a, swe_a}, {8'h22, 8'h33, 1'b1});
        chk("init_start_once", is_a, 1'b0);
        man_dec_fin = 1'b1; man_dec_valid = 1'b1; man_shuf_fin = 1'b1;
        tick();
        man_dec_fin = 1'b0; man_dec_valid = 1'b0; man_shuf_fin = 1'b0;
        chk("stray_finish_ignored", st_a, ST_INIT_WAIT);
        man_init_fin = 1'b1;
        tick();
        man_init_fin = 1'b0;
        chk("shuf_go_state", st_a, ST_SHUF_GO);
        chk("shuf_go_sport", {ss_a, saddr_a, swdata_a, swe_a}, {1'b1, 8'h10, 8'h44, 1'b1});
        tick();
        man_shuf_fin = 1'b1;
        tick();
        man_shuf_fin = 1'b0;
        chk("dec_go_sport", {ds_a, saddr_a, swdata_a, swe_a}, {1'b1, 8'h55, 8'h66, 1'b1});
        tick();
        chk("dec_wait_state", st_a, ST_DEC_WAIT);
        man_dec_fin = 1'b1; man_dec_valid = 1'b0;
        tick();
        man_dec_fin = 1'b0;
        chk("next_key_state", st_a, ST_NEXT_KEY);
        chk("next_key_sport", {saddr_a, swdata_a, swe_a}, 17'd0);
        chk("next_key_hold", key_a, 24'h000000);
        tick();
        chk("second_key", {st_a, key_a}, {ST_INIT_GO, 24'h000001});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        init_we = 1'b0; shuf_we = 1'b0; dec_we = 1'b0;

        // search with success on key 2
        stub_en = 1'b1; sel = 0; target = 24'h000002;
        n0 = n_init;
        start_a = 1'b1;
        wait_st(0, ST_FOUND, 200, "found_reached");
        chk("found_init_pulses", n_init - n0, 3);
        chk("found_key", key_a, 24'h000002);
        chk("found_flags", {found_a, busy_a, exh_a}, 3'b100);
        repeat (5) tick();
        chk("found_no_retrigger", {st_a, key_a}, {ST_FOUND, 24'h000002});
        start_a = 1'b0;
        tick();
        chk("found_to_idle", {st_a, found_a, key_a}, {ST_IDLE, 1'b0, 24'h000002});

        // reset in the middle of DEC_WAIT on key 5
        target = 24'hFFFFFF;
        start_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (st_a == ST_DEC_WAIT && key_a == 24'h000005) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dec_wait_key5_reached", {31'd0, ok}, 32'd1);
        start_a = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrun_rst", {st_a, key_a, swe_a, busy_a}, {ST_IDLE, 24'h000000, 1'b0, 1'b0});
        rst_n = 1'b1;
        tick();

        // top-of-range exhaustion, no wrap
        sel = 1;
        base = att_q.size();
        start_b = 1'b1;
        wait_st(1, ST_FAIL, 100, "exhaust_reached");
        exp_q.push_back(24'h3FFFFE);
        exp_q.push_back(24'h3FFFFF);
        check_attempts(base, "exhaust_keys");
        chk("exhaust_flags", {exh_b, found_b, busy_b, key_b}, {3'b100, 24'h3FFFFF});
        repeat (3) tick();
        chk("exhaust_hold", {st_b, key_b}, {ST_FAIL, 24'h3FFFFF});
        start_b = 1'b0;
        tick();
        chk("exhaust_to_idle", st_b, ST_IDLE);

        // step of 2 from key 1
        sel = 2;
        base = att_q.size();
        start_c = 1'b1;
        wait_st(2, ST_FAIL, 100, "step2_reached");
        exp_q.push_back(24'h000001);
        exp_q.push_back(24'h000003);
        exp_q.push_back(24'h000005);
        check_attempts(base, "step2_keys");
        chk("step2_final", {exh_c, key_c}, {1'b1, 24'h000005});
        chk("step2_no_even", even_seen, 1'b0);
        start_c = 1'b0;
        tick();

`ifdef RC4_CTRL_STOP_EN
        // stop during SHUF_WAIT drains the shuffle engine, then FAIL
        stub_en = 1'b0; sel = 0;
        shuf_we = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        man_init_fin = 1'b1;
        tick();
        man_init_fin = 1'b0;
        tick();
        chk("stop_pre_state", st_a, ST_SHUF_WAIT);
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        chk("stop_drain", st_a, ST_DRAIN);
        n0 = 0;
        for (int i = 0; i < 4; i++) begin
            if (ds_a) n0++;
            tick();
        end
        chk("drain_hold", {st_a, saddr_a, swe_a, busy_a}, {ST_DRAIN, 8'h10, 1'b1, 1'b1});
        chk("drain_no_dec_start", n0 + ds_a, 0);
        man_shuf_fin = 1'b1;
        tick();
        man_shuf_fin = 1'b0;
        chk("drain_to_fail", {st_a, exh_a, found_a, swe_a}, {ST_FAIL, 1'b1, 1'b0, 1'b0});
        shuf_we = 1'b0;
        tick();
        chk("stop_fail_to_idle", st_a, ST_IDLE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
